// File: rtl/heap_shift_controller.sv
// Multi-cycle insert-at-index sequencer for one array area of the single-port heap.
// Optional macro SHIFT_DOWN_EN adds remove-at-index (req_op=1); default build is shift up only.
module heap_shift_controller #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 20,
    parameter int HeapAddrWidth      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [MemoryElementWidth-1:0] req_array,
    input  logic [MemoryElementWidth-1:0] req_index,
    input  logic [MemoryElementWidth-1:0] req_value,
    input  logic [MemoryElementWidth-1:0] req_size,
    input  logic                          req_op,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] done_size,
    output logic [MemoryElementWidth-1:0] done_value,
    output logic [HeapAddrWidth-1:0]      mem_addr,
    output logic                          mem_we,
    output logic [MemoryElementWidth-1:0] mem_wdata,
    input  logic [MemoryElementWidth-1:0] mem_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CHECK   = 3'd1;
    localparam logic [2:0] READ    = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] INSERT  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] CAPTURE = 3'd6;

    localparam logic [MemoryElementWidth-1:0] AREA_LEN   = MemoryElementWidth'(NArea);
    localparam logic [MemoryElementWidth-1:0] ARRAY_CNT  = MemoryElementWidth'(NArrays);
    localparam logic [MemoryElementWidth-1:0] ELEM_ONE   = MemoryElementWidth'(1);
    localparam logic [HeapAddrWidth-1:0]      AREA_ADDR  = HeapAddrWidth'(NArea);
    localparam logic [HeapAddrWidth-1:0]      ADDR_ONE   = HeapAddrWidth'(1);

    logic [2:0]                    state;
    logic [MemoryElementWidth-1:0] arr_q;
    logic [MemoryElementWidth-1:0] idx_q;
    logic [MemoryElementWidth-1:0] val_q;
    logic [MemoryElementWidth-1:0] size_q;
    logic [MemoryElementWidth-1:0] k;
    logic [MemoryElementWidth-1:0] removed;
    logic                          op_q;
    logic                          err_q;
    logic                          down_req;
    logic                          bad_req;
    logic [HeapAddrWidth-1:0]      base;
    logic [HeapAddrWidth-1:0]      k_addr;

`ifdef SHIFT_DOWN_EN
    assign down_req = req_op;
`else
    logic unused_op;
    assign unused_op = req_op;
    assign down_req  = 1'b0;
`endif

    // Removal needs an element at the index; insertion may append at index == size.
    assign bad_req = (size_q >= AREA_LEN) || (arr_q >= ARRAY_CNT) ||
                     (op_q ? (idx_q >= size_q) : (idx_q > size_q));

    assign base      = HeapAddrWidth'(arr_q) * AREA_ADDR;
    assign k_addr    = base + HeapAddrWidth'(k);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            arr_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            size_q  <= '0;
            k       <= '0;
            removed <= '0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        arr_q   <= req_array;
                        idx_q   <= req_index;
                        val_q   <= req_value;
                        size_q  <= req_size;
                        op_q    <= down_req;
                        removed <= '0;
                        err_q   <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    err_q <= bad_req;
                    if (bad_req) begin
                        state <= DONE;
                    end else if (op_q) begin
                        k     <= idx_q;
                        state <= READ;
                    end else if (idx_q == size_q) begin
                        state <= INSERT;
                    end else begin
                        k     <= size_q - ELEM_ONE;
                        state <= READ;
                    end
                end
                // The first read of a removal fetches the element being removed.
                READ: begin
                    state <= (op_q && (k == idx_q)) ? CAPTURE : WRITE;
                end
                CAPTURE: begin
                    removed <= mem_rdata;
                    if (k + ELEM_ONE == size_q) begin
                        state <= DONE;
                    end else begin
                        k     <= k + ELEM_ONE;
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (op_q) begin
                        if (k == size_q - ELEM_ONE) begin
                            state <= DONE;
                        end else begin
                            k     <= k + ELEM_ONE;
                            state <= READ;
                        end
                    end else if (k == idx_q) begin
                        state <= INSERT;
                    end else begin
                        k     <= k - ELEM_ONE;
                        state <= READ;
                    end
                end
                INSERT:  state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Shift up copies k to k+1 (highest first); shift down copies k to k-1 (lowest first).
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            READ: begin
                mem_addr = k_addr;
            end
            WRITE: begin
                mem_addr  = op_q ? (k_addr - ADDR_ONE) : (k_addr + ADDR_ONE);
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
            end
            INSERT: begin
                mem_addr  = base + HeapAddrWidth'(idx_q);
                mem_we    = 1'b1;
                mem_wdata = val_q;
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
    end

    always_comb begin
        done       = (state == DONE);
        error      = done && err_q;
        done_size  = '0;
        done_value = '0;
        if (done) begin
            if (err_q) begin
                done_size = size_q;
            end else if (op_q) begin
                done_size  = size_q - ELEM_ONE;
                done_value = removed;
            end else begin
                done_size = size_q + ELEM_ONE;
            end
        end
    end

endmodule
